// File: rtl/vend_pkg.sv
// Shared definitions for the vending payout block: coin encodings, values, states, widths.
package vend_pkg;

    localparam int unsigned DollarW  = 1;
    localparam int unsigned QuarterW = 2;
    localparam int unsigned DimeW    = 4;
    localparam int unsigned NickelW  = 5;
    localparam int unsigned CodeW    = 3;
    localparam int unsigned PaidW    = 9;

    localparam logic [1:0] CoinNickel  = 2'b00;
    localparam logic [1:0] CoinDime    = 2'b01;
    localparam logic [1:0] CoinQuarter = 2'b10;
    localparam logic [1:0] CoinDollar  = 2'b11;

    localparam logic [PaidW-1:0] ValNickel  = 9'd5;
    localparam logic [PaidW-1:0] ValDime    = 9'd10;
    localparam logic [PaidW-1:0] ValQuarter = 9'd25;
    localparam logic [PaidW-1:0] ValDollar  = 9'd100;

    typedef enum logic [2:0] {
        StIdle,
        StItem,
        StDollar,
        StQuarter,
        StDime,
        StNickel,
        StFin
    } state_e;

    // nz = {dollar, quarter, dime, nickel} nonzero flags; picks the largest pending coin.
    function automatic state_e first_coin_state(input logic [3:0] nz);
        state_e st;
        if (nz[3])      st = StDollar;
        else if (nz[2]) st = StQuarter;
        else if (nz[1]) st = StDime;
        else if (nz[0]) st = StNickel;
        else            st = StFin;
        return st;
    endfunction

    function automatic logic [PaidW-1:0] coin_value(input logic [1:0] ct);
        logic [PaidW-1:0] v;
        case (ct)
            CoinDollar:  v = ValDollar;
            CoinQuarter: v = ValQuarter;
            CoinDime:    v = ValDime;
            default:     v = ValNickel;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vend_coin_cnt.sv
// Loadable down counter for one coin denomination, with zero and last-coin flags.
module vend_coin_cnt #(
    parameter int unsigned Width = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    input  logic             dec,
    output logic             zero,
    output logic             last
);

    logic [Width-1:0] count_q, count_d;

    // Next count: load wins over decrement; never wraps below zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - Width'(1);
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);
    // Last coin: an acked decrement now empties the counter.
    assign last = (count_q == Width'(1));

endmodule

// File: rtl/vend_payout.sv
// Vending payout sequencer: releases the item, then ejects change largest coin first.
module vend_payout
    import vend_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                item_req,
    input  logic [CodeW-1:0]    item_dispensed,
    input  logic [DollarW-1:0]  change_dollar,
    input  logic [QuarterW-1:0] change_quarters,
    input  logic [DimeW-1:0]    change_dimes,
    input  logic [NickelW-1:0]  change_nickels,
    output logic                busy,
    output logic                item_valid,
    output logic [CodeW-1:0]    item_code,
    input  logic                item_ack,
    output logic                coin_valid,
    output logic [1:0]          coin_type,
    input  logic                coin_ack,
    output logic [PaidW-1:0]    paid_cents,
    output logic                done
);

    state_e            state_q, state_d;
    logic [CodeW-1:0]  code_q, code_d;
    logic [PaidW-1:0]  paid_q, paid_d;
    logic              accept;
    logic [3:0]        zero, last, dec;
    logic [3:0]        nz;
    logic [3:0]        load_nz;

    assign accept  = (state_q == StIdle) && load;
    assign nz      = ~zero;
    assign load_nz = {|change_dollar, |change_quarters, |change_dimes, |change_nickels};

    assign dec[3] = coin_ack && (state_q == StDollar);
    assign dec[2] = coin_ack && (state_q == StQuarter);
    assign dec[1] = coin_ack && (state_q == StDime);
    assign dec[0] = coin_ack && (state_q == StNickel);

    vend_coin_cnt #(.Width(DollarW)) u_cnt_dollar (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (change_dollar),
        .dec      (dec[3]),
        .zero     (zero[3]),
        .last     (last[3])
    );

    vend_coin_cnt #(.Width(QuarterW)) u_cnt_quarter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (change_quarters),
        .dec      (dec[2]),
        .zero     (zero[2]),
        .last     (last[2])
    );

    vend_coin_cnt #(.Width(DimeW)) u_cnt_dime (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (change_dimes),
        .dec      (dec[1]),
        .zero     (zero[1]),
        .last     (last[1])
    );

    vend_coin_cnt #(.Width(NickelW)) u_cnt_nickel (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (change_nickels),
        .dec      (dec[0]),
        .zero     (zero[0]),
        .last     (last[0])
    );

    // Next-state: on the last coin of a denomination jump straight to the next nonzero one.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (load) begin
                    state_d = item_req ? StItem : first_coin_state(load_nz);
                end
            end
            StItem: begin
                if (item_ack) state_d = first_coin_state(nz);
            end
            StDollar: begin
                if (coin_ack && last[3]) state_d = first_coin_state({1'b0, nz[2:0]});
            end
            StQuarter: begin
                if (coin_ack && last[2]) state_d = first_coin_state({2'b00, nz[1:0]});
            end
            StDime: begin
                if (coin_ack && last[1]) state_d = first_coin_state({3'b000, nz[0]});
            end
            StNickel: begin
                if (coin_ack && last[0]) state_d = StFin;
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Item code capture and change accumulator.
    always_comb begin
        code_d = code_q;
        paid_d = paid_q;
        if (accept) begin
            code_d = item_dispensed;
            paid_d = '0;
        end else if (coin_valid && coin_ack) begin
            paid_d = paid_q + coin_value(coin_type);
        end
    end

    // State, code and accumulator registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            code_q  <= '0;
            paid_q  <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            paid_q  <= paid_d;
        end
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        busy       = (state_q != StIdle);
        item_valid = 1'b0;
        item_code  = '0;
        coin_valid = 1'b0;
        coin_type  = CoinNickel;
        done       = 1'b0;
        unique case (state_q)
            StItem: begin
                item_valid = 1'b1;
                item_code  = code_q;
            end
            StDollar: begin
                coin_valid = 1'b1;
                coin_type  = CoinDollar;
            end
            StQuarter: begin
                coin_valid = 1'b1;
                coin_type  = CoinQuarter;
            end
            StDime: begin
                coin_valid = 1'b1;
                coin_type  = CoinDime;
            end
            StNickel: begin
                coin_valid = 1'b1;
                coin_type  = CoinNickel;
            end
            StFin: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign paid_cents = paid_q;

endmodule

// File: tb/tb_vend_payout.sv
// Scoreboard bench for vend_payout: expected releases queued at load, popped on handshakes.
module tb_vend_payout;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load;
    logic       item_req;
    logic [2:0] item_dispensed;
    logic       change_dollar;
    logic [1:0] change_quarters;
    logic [3:0] change_dimes;
    logic [4:0] change_nickels;
    logic       busy;
    logic       item_valid;
    logic [2:0] item_code;
    logic       item_ack;
    logic       coin_valid;
    logic [1:0] coin_type;
    logic       coin_ack;
    logic [8:0] paid_cents;
    logic       done;

    vend_payout dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .load            (load),
        .item_req        (item_req),
        .item_dispensed  (item_dispensed),
        .change_dollar   (change_dollar),
        .change_quarters (change_quarters),
        .change_dimes    (change_dimes),
        .change_nickels  (change_nickels),
        .busy            (busy),
        .item_valid      (item_valid),
        .item_code       (item_code),
        .item_ack        (item_ack),
        .coin_valid      (coin_valid),
        .coin_type       (coin_type),
        .coin_ack        (coin_ack),
        .paid_cents      (paid_cents),
        .done            (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    // Expected releases: 8+code for an item, 0..3 for a coin type.
    int exp_q[$];
    int paid_exp[$];
    int ack_mode = 0;  // 0: ack always, 1: every other cycle, 2: never
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int xfer_cnt = 0;
    logic       stall_q = 1'b0;
    logic [1:0] stall_type = 2'b00;

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Ack driver and output monitor, both on the falling edge.
    initial begin
        logic a;
        item_ack = 1'b0;
        coin_ack = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n && stall_q) begin
                check_eq("stall_valid_held", int'(coin_valid), 1);
                check_eq("stall_type_stable", int'(coin_type), int'(stall_type));
            end
            case (ack_mode)
                0:       a = 1'b1;
                1:       a = cyc[0];
                default: a = 1'b0;
            endcase
            item_ack   = a;
            coin_ack   = a;
            stall_q    = rst_n && coin_valid && !a;
            stall_type = coin_type;
            if (rst_n && item_valid && a) begin
                xfer_cnt++;
                if (exp_q.size() > 0) check_eq("item_release", 8 + int'(item_code), exp_q.pop_front());
                else                  check_eq("unexpected_item", int'(item_code), -1);
            end
            if (rst_n && coin_valid && a) begin
                xfer_cnt++;
                if (exp_q.size() > 0) check_eq("coin_order", int'(coin_type), exp_q.pop_front());
                else                  check_eq("unexpected_coin", int'(coin_type), -1);
            end
            if (rst_n && done) begin
                done_cnt++;
                done_cyc = cyc;
                if (paid_exp.size() > 0) check_eq("paid_at_done", int'(paid_cents), paid_exp.pop_front());
                else                     check_eq("unexpected_done", int'(paid_cents), -1);
                check_eq("queue_drained_at_done", exp_q.size(), 0);
            end
        end
    end

    // Independent model of one order: item first, then largest coins first.
    task automatic push_order(input logic ir, input int code, input int d, input int q,
                              input int di, input int n);
        if (ir) exp_q.push_back(8 + code);
        repeat (d)  exp_q.push_back(3);
        repeat (q)  exp_q.push_back(2);
        repeat (di) exp_q.push_back(1);
        repeat (n)  exp_q.push_back(0);
        paid_exp.push_back(100 * d + 25 * q + 10 * di + 5 * n);
    endtask

    // Entered at posedge+2; returns 2 time units after the capturing edge.
    task automatic drive_load(input logic ir, input logic [2:0] code, input logic d,
                              input logic [1:0] q, input logic [3:0] di, input logic [4:0] n);
        load            = 1'b1;
        item_req        = ir;
        item_dispensed  = code;
        change_dollar   = d;
        change_quarters = q;
        change_dimes    = di;
        change_nickels  = n;
        @(posedge clk);
        #2;
        load            = 1'b0;
    endtask

    task automatic wait_done(input int start_cnt, input string tag);
        int k = 0;
        while (done_cnt == start_cnt && k < 300) begin
            @(posedge clk);
            k++;
        end
        check_eq({tag, "_done_once"}, done_cnt, start_cnt + 1);
        @(posedge clk);
        #2;
        check_eq({tag, "_idle_after"}, int'(busy), 0);
    endtask

    initial begin
        int s;
        int c0;
        int base;
        int k;
        rst_n           = 1'b0;
        load            = 1'b0;
        item_req        = 1'b0;
        item_dispensed  = '0;
        change_dollar   = '0;
        change_quarters = '0;
        change_dimes    = '0;
        change_nickels  = '0;
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_item_valid", int'(item_valid), 0);
        check_eq("rst_item_code", int'(item_code), 0);
        check_eq("rst_coin_valid", int'(coin_valid), 0);
        check_eq("rst_coin_type", int'(coin_type), 0);
        check_eq("rst_paid", int'(paid_cents), 0);
        check_eq("rst_done", int'(done), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // Item 6 plus quarter, dime, nickel with acks held high.
        ack_mode = 0;
        push_order(1'b1, 6, 0, 1, 1, 1);
        s = done_cnt;
        drive_load(1'b1, 3'd6, 1'b0, 2'd1, 4'd1, 5'd1);
        c0 = cyc;
        check_eq("o1_busy", int'(busy), 1);
        check_eq("o1_item_valid_n1", int'(item_valid), 1);
        check_eq("o1_item_code", int'(item_code), 6);
        wait_done(s, "o1");
        check_eq("o1_latency", done_cyc - c0, 5);
        check_eq("o1_paid_hold", int'(paid_cents), 40);

        // Three nickels, ack every other cycle.
        ack_mode = 1;
        push_order(1'b0, 0, 0, 0, 0, 3);
        s = done_cnt;
        drive_load(1'b0, 3'd0, 1'b0, 2'd0, 4'd0, 5'd3);
        check_eq("o2_coin_valid_n1", int'(coin_valid), 1);
        check_eq("o2_paid_cleared", int'(paid_cents), 0);
        wait_done(s, "o2");
        check_eq("o2_paid_hold", int'(paid_cents), 15);

        // Maximum order: 50 coins back to back.
        ack_mode = 0;
        push_order(1'b0, 0, 1, 3, 15, 31);
        s = done_cnt;
        drive_load(1'b0, 3'd0, 1'b1, 2'd3, 4'd15, 5'd31);
        c0 = cyc;
        check_eq("o3_first_type", int'(coin_type), 3);
        wait_done(s, "o3");
        check_eq("o3_latency", done_cyc - c0, 51);
        check_eq("o3_paid_hold", int'(paid_cents), 480);

        // Empty order, plus a load presented during FIN that must be ignored.
        push_order(1'b0, 0, 0, 0, 0, 0);
        s = done_cnt;
        drive_load(1'b0, 3'd0, 1'b0, 2'd0, 4'd0, 5'd0);
        check_eq("o4_done_n1", int'(done), 1);
        check_eq("o4_no_item", int'(item_valid), 0);
        check_eq("o4_no_coin", int'(coin_valid), 0);
        drive_load(1'b0, 3'd0, 1'b0, 2'd0, 4'd0, 5'd7);
        check_eq("o4_fin_load_ignored", int'(busy), 0);
        wait_done(s, "o4");
        repeat (3) @(posedge clk);
        #2;
        check_eq("o4_no_extra_done", done_cnt, s + 1);
        check_eq("o4_paid", int'(paid_cents), 0);

        // Load while busy with different counts must not disturb the order.
        ack_mode = 1;
        push_order(1'b1, 3, 1, 2, 0, 0);
        s = done_cnt;
        drive_load(1'b1, 3'd3, 1'b1, 2'd2, 4'd0, 5'd0);
        repeat (3) @(posedge clk);
        #2;
        drive_load(1'b1, 3'd1, 1'b0, 2'd0, 4'd9, 5'd5);
        wait_done(s, "o5");
        check_eq("o5_paid_hold", int'(paid_cents), 150);

        // Reset with two dimes left abandons the order.
        ack_mode = 0;
        push_order(1'b0, 0, 0, 0, 4, 0);
        s = done_cnt;
        base = xfer_cnt;
        drive_load(1'b0, 3'd0, 1'b0, 2'd0, 4'd4, 5'd0);
        k = 0;
        while (xfer_cnt < base + 2 && k < 50) begin
            @(posedge clk);
            k++;
        end
        check_eq("o6_two_dimes_out", xfer_cnt, base + 2);
        #2;
        rst_n    = 1'b0;
        ack_mode = 2;
        @(posedge clk);
        #2;
        check_eq("o6_rst_busy", int'(busy), 0);
        check_eq("o6_rst_coin_valid", int'(coin_valid), 0);
        check_eq("o6_rst_paid", int'(paid_cents), 0);
        check_eq("o6_rst_done", int'(done), 0);
        exp_q.delete();
        paid_exp.delete();
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check_eq("o6_no_done", done_cnt, s);

        // Fresh order after the abandoned one.
        ack_mode = 0;
        push_order(1'b1, 5, 0, 0, 2, 1);
        s = done_cnt;
        drive_load(1'b1, 3'd5, 1'b0, 2'd0, 4'd2, 5'd1);
        check_eq("o7_item_code", int'(item_code), 5);
        wait_done(s, "o7");
        check_eq("o7_paid_hold", int'(paid_cents), 25);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
